fft_share_arbiter: RTL and testbench
====================================

# fft_share_arbiter

Arbiter that time-shares one add_FFT evaluation engine between two requesters in SHARED builds. Port 0 is the key-generation/encapsulation side; port 1 is the decryption side (fft_*_dec). It queues start requests and grants the engine for whole jobs, round-robin. A job runs from launch through read-out of the evaluation memory until the owner releases it. It routes start, coefficients, read port and done to and from the current owner.

## Interface
- m, 13, field width
- t, 119, number of errors; coefficient vector is m*(t+1) bits
- mem_width, 32, add_FFT memory width
- eva_mem_WIDTH, 2*m*mem_width, evaluation read-data width
- ADDR_W, `CLOG2(t+1), evaluation read-address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reqN_start  in  1  one-cycle job request (N = 0, 1)
- reqN_coeff  in  m*(t+1)  polynomial coefficients; held stable from reqN_start until reqN_gnt
- reqN_rd_en  in  1  evaluation-memory read enable
- reqN_rd_addr  in  ADDR_W  evaluation-memory read address
- reqN_release  in  1  one-cycle pulse: owner has finished reading
- reqN_gnt  out  1  requester N owns the engine
- reqN_done  out  1  add_FFT done, forwarded to the owner only
- reqN_dout  out  eva_mem_WIDTH  fft_dout broadcast; valid for the owner only
- fft_start  out  1  registered one-cycle start to add_FFT
- fft_coeff_in  out  m*(t+1)  owner's coefficients; zero when no owner
- fft_rd_en  out  1  owner's rd_en; 0 when no owner
- fft_rd_addr  out  ADDR_W  owner's rd_addr; 0 when no owner
- fft_dout  in  eva_mem_WIDTH  add_FFT data out
- fft_done  in  1  add_FFT done pulse
- proto_err  out  1  sticky protocol-violation flag

## Operation
- State registers: pend0, pend1, owner (1 bit), last (1 bit), state ∈ {IDLE, RUN, HOLD}.
- pendN is set by reqN_start. It is cleared on the edge that grants N. A start while pendN is already 1 is absorbed (no count).
- IDLE, at least one pend set → RUN:
  - owner = winner; gnt asserted; fft_start = 1 for one cycle; pend[winner] cleared; last = winner.
  - Winner: the only pending requester; if both pend, the one ≠ last.
- RUN, fft_done → HOLD. reqN_done = fft_done & gnt_N, combinational.
- HOLD, release from owner → IDLE; gnt drops on that edge. A new grant is possible on the next edge.
- Routing: fft_coeff_in, fft_rd_en and fft_rd_addr are muxed combinationally from the owner in RUN and HOLD. They are forced to 0 in IDLE. The non-owner's rd_en is ignored.
- The owner may pulse start while in HOLD, including in the same cycle as its release. This sets its pend and queues the job normally; round-robin still applies.
- proto_err sets, sticky until reset, on any of:
  - owner start during RUN; the start is ignored, not queued.
  - owner release during RUN; the release is ignored.
  - release from a non-owner or while in IDLE.
  - fft_done in IDLE or HOLD; ignored.

## Timing
- Reset (async, rst_n = 0): state = IDLE, pend = 0, owner = 0, last = 1 (port 0 wins first tie), fft_start = 0, proto_err = 0. All outputs go to 0 immediately, including gnt, done and the fft_* mux outputs. An in-flight job is abandoned; the requester must restart it.
- Start → fft_start latency from idle: reqN_start in cycle k → pendN = 1 in k+1 → fft_start and reqN_gnt high in cycle k+2.
- fft_start is high exactly one cycle, coincident with the first gnt cycle. fft_coeff_in already shows the owner's coefficients in that cycle.
- Release in cycle r → gnt low in r+1; state IDLE in r+1. A pending job launches with fft_start in r+2.
- reqN_done is zero-latency from fft_done.
- Reads are forwarded combinationally, so read latency equals add_FFT latency. The owner keeps gnt through HOLD for trailing reads.
- Simultaneous starts from both ports in IDLE: both pend set; the winner is ≠ last; the loser launches after the winner releases.

## Test plan
- Single job, port 1: start at cycle 10 → fft_start and gnt1 at cycle 12. fft_done at 40 → req1_done at 40, req0_done = 0. Release at 50 → gnt1 = 0 at 51; fft_rd_en tracks req1_rd_en during 12–50.
- Simultaneous starts after reset (last = 1) → port 0 granted first. After its release, port 1's fft_start comes 2 cycles later. Next tie goes to port 1.
- Port 0 starts during port 1's RUN → queued; fft_start for port 0 is exactly 2 cycles after port 1's release. Coefficients switch to req0_coeff on that cycle.
- Owner start during RUN, and release in IDLE → proto_err = 1 and stays 1; no extra fft_start is issued.
- rst_n low mid-RUN → gnt, fft_start and fft_rd_en go to 0 asynchronously. After rst_n rises, a fresh start from port 1 launches with 2-cycle latency; proto_err = 0.

Source files
------------

// File: rtl/fft_share_arbiter_if.sv
// Requester-side bundle for the shared add_FFT engine: one job request
// channel (start/coefficients/release), the read port into the evaluation
// memory, and the grant/done/data returned by the arbiter.
interface fft_share_arbiter_if #(
  parameter int COEF_W = 1560,
  parameter int ADDR_W = 7,
  parameter int DOUT_W = 832
);
  logic              start;
  logic [COEF_W-1:0] coeff;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              release_job;
  logic              gnt;
  logic              done;
  logic [DOUT_W-1:0] dout;

  // requester drives the request side and observes the grant side
  modport master (
    output start, coeff, rd_en, rd_addr, release_job,
    input  gnt, done, dout
  );

  // arbiter observes the request side and drives the grant side
  modport slave (
    input  start, coeff, rd_en, rd_addr, release_job,
    output gnt, done, dout
  );
endinterface

// File: rtl/fft_share_arbiter.sv
// Time-shares one add_FFT evaluation engine between two requesters.
// Port 0 is the keygen/encapsulation side, port 1 the decryption side.
// Jobs are granted whole (launch -> done -> trailing reads -> release),
// round-robin between queued requests; start, coefficients, read port and
// done are routed to and from the current owner only.
module fft_share_arbiter #(
  parameter int m             = 13,
  parameter int t             = 119,
  parameter int mem_width     = 32,
  parameter int eva_mem_WIDTH = 2 * m * mem_width,
  parameter int ADDR_W        = $clog2(t + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fft_share_arbiter_if.slave       req0,
  fft_share_arbiter_if.slave       req1,
  output logic                     fft_start,
  output logic [m*(t+1)-1:0]       fft_coeff_in,
  output logic                     fft_rd_en,
  output logic [ADDR_W-1:0]        fft_rd_addr,
  input  logic [eva_mem_WIDTH-1:0] fft_dout,
  input  logic                     fft_done,
  output logic                     proto_err
);

  localparam int COEF_W = m * (t + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state, state_nx;
  logic [1:0]  pend, pend_nx;
  logic        owner, owner_nx;
  logic        last, last_nx;
  logic        start_nx;
  logic        err_nx;
  logic        winner;
  logic        busy;
  logic [1:0]  start_v;
  logic [1:0]  rel_v;

  assign start_v = {req1.start, req0.start};
  assign rel_v   = {req1.release_job, req0.release_job};
  assign busy    = (state != IDLE);

  // round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    case (pend)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last;
    endcase
  end

  // next-state, queueing and protocol checking
  always_comb begin
    state_nx = state;
    pend_nx  = pend | start_v;
    owner_nx = owner;
    last_nx  = last;
    start_nx = 1'b0;
    err_nx   = proto_err;
    case (state)
      IDLE: begin
        // nobody owns the engine, so any release or done is stray
        if ((|rel_v) || fft_done) err_nx = 1'b1;
        if (|pend) begin
          state_nx        = RUN;
          owner_nx        = winner;
          last_nx         = winner;
          start_nx        = 1'b1;
          pend_nx[winner] = 1'b0;
        end
      end
      RUN: begin
        // a restart by the owner mid-job is dropped, not queued
        if (start_v[owner]) begin
          err_nx         = 1'b1;
          pend_nx[owner] = pend[owner];
        end
        // release before done (owner) or from the non-owner is ignored
        if (|rel_v) err_nx = 1'b1;
        if (fft_done) state_nx = HOLD;
      end
      HOLD: begin
        if (rel_v[~owner] || fft_done) err_nx = 1'b1;
        if (rel_v[owner]) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // control registers; an in-flight job is abandoned on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= 2'b00;
      owner     <= 1'b0;
      last      <= 1'b1;
      fft_start <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      fft_start <= start_nx;
      proto_err <= err_nx;
    end
  end

  assign req0.gnt  = busy & ~owner;
  assign req1.gnt  = busy & owner;
  assign req0.done = fft_done & req0.gnt;
  assign req1.done = fft_done & req1.gnt;
  assign req0.dout = fft_dout;
  assign req1.dout = fft_dout;

  // engine-side mux: owner's coefficients and read port, zero when idle
  always_comb begin
    fft_coeff_in = '0;
    fft_rd_en    = 1'b0;
    fft_rd_addr  = '0;
    if (busy) begin
      if (owner) begin
        fft_coeff_in = req1.coeff;
        fft_rd_en    = req1.rd_en;
        fft_rd_addr  = req1.rd_addr;
      end else begin
        fft_coeff_in = req0.coeff;
        fft_rd_en    = req0.rd_en;
        fft_rd_addr  = req0.rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_fft_share_arbiter.sv
// Testbench for fft_share_arbiter: vector table, directed corner sequences
// and randomized traffic against a job-level reference model.
module tb_fft_share_arbiter;
  localparam int M      = 13;
  localparam int T      = 119;
  localparam int MW     = 32;
  localparam int COEF_W = M * (T + 1);
  localparam int DOUT_W = 2 * M * MW;
  localparam int ADDR_W = $clog2(T + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_share_arbiter_if #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .DOUT_W(DOUT_W)) req0();
  fft_share_arbiter_if #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .DOUT_W(DOUT_W)) req1();

  logic              fft_start;
  logic [COEF_W-1:0] fft_coeff_in;
  logic              fft_rd_en;
  logic [ADDR_W-1:0] fft_rd_addr;
  logic [DOUT_W-1:0] fft_dout;
  logic              fft_done;
  logic              proto_err;

  fft_share_arbiter #(.m(M), .t(T), .mem_width(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .fft_start(fft_start), .fft_coeff_in(fft_coeff_in), .fft_rd_en(fft_rd_en),
    .fft_rd_addr(fft_rd_addr), .fft_dout(fft_dout), .fft_done(fft_done),
    .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: who owns the engine (-1 = nobody), whether its done
  // has arrived, which ports wait, who was served last
  int m_owner;
  bit m_done_seen;
  bit m_pend [2];
  int m_last;
  bit m_fs;
  bit m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [COEF_W-1:0] rand_coeff();
    logic [COEF_W+31:0] tmp;
    for (int i = 0; i < COEF_W; i += 32) tmp[i +: 32] = $urandom;
    return tmp[COEF_W-1:0];
  endfunction

  function automatic logic [DOUT_W-1:0] rand_dout();
    logic [DOUT_W+31:0] tmp;
    for (int i = 0; i < DOUT_W; i += 32) tmp[i +: 32] = $urandom;
    return tmp[DOUT_W-1:0];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_done_seen = 0; m_pend[0] = 0; m_pend[1] = 0;
    m_last = 1; m_fs = 0; m_err = 0;
  endtask

  task automatic model_update();
    bit st [2];
    bit rl [2];
    bit dn;
    int w, o, x;
    if (!rst_n) begin
      model_reset();
      return;
    end
    st[0] = req0.start; st[1] = req1.start;
    rl[0] = req0.release_job; rl[1] = req1.release_job;
    dn = fft_done;
    m_fs = 0;
    if (m_owner < 0) begin
      if (rl[0] || rl[1] || dn) m_err = 1;
      if (m_pend[0] || m_pend[1]) begin
        if (m_pend[0] && m_pend[1]) w = 1 - m_last;
        else w = m_pend[0] ? 0 : 1;
        if (st[1-w]) m_pend[1-w] = 1;
        m_pend[w] = 0;
        m_owner = w; m_last = w; m_done_seen = 0; m_fs = 1;
      end else begin
        if (st[0]) m_pend[0] = 1;
        if (st[1]) m_pend[1] = 1;
      end
    end else begin
      o = m_owner; x = 1 - o;
      if (st[x]) m_pend[x] = 1;
      if (rl[x]) m_err = 1;
      if (!m_done_seen) begin
        if (st[o] || rl[o]) m_err = 1;
        if (dn) m_done_seen = 1;
      end else begin
        if (dn) m_err = 1;
        if (st[o]) m_pend[o] = 1;
        if (rl[o]) m_owner = -1;
      end
    end
  endtask

  task automatic check_model();
    logic [COEF_W-1:0] ec;
    logic              er;
    logic [ADDR_W-1:0] ea;
    bit g0, g1;
    g0 = (m_owner == 0); g1 = (m_owner == 1);
    ec = '0; er = 1'b0; ea = '0;
    if (g0) begin ec = req0.coeff; er = req0.rd_en; ea = req0.rd_addr; end
    if (g1) begin ec = req1.coeff; er = req1.rd_en; ea = req1.rd_addr; end
    check("m_gnt0", req0.gnt, g0);
    check("m_gnt1", req1.gnt, g1);
    check("m_done0", req0.done, fft_done & g0);
    check("m_done1", req1.done, fft_done & g1);
    check("m_fft_start", fft_start, m_fs);
    check("m_rd_en", fft_rd_en, er);
    check("m_rd_addr", fft_rd_addr, ea);
    check("m_proto_err", proto_err, m_err);
    n_cmp++;
    if (fft_coeff_in !== ec) begin
      n_fail++;
      $display("FAIL m_coeff: got low %h, expected low %h", fft_coeff_in[63:0], ec[63:0]);
    end
    n_cmp++;
    if (req0.dout !== fft_dout || req1.dout !== fft_dout) begin
      n_fail++;
      $display("FAIL m_dout: got low %h/%h, expected low %h", req0.dout[63:0], req1.dout[63:0], fft_dout[63:0]);
    end
  endtask

  // one clock: check against the model mid-cycle, advance it on the edge
  task automatic cyc();
    @(negedge clk);
    if (!rst_n) model_reset();
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit s0, input bit s1, input bit r0, input bit r1, input bit dn);
    req0.start = s0; req1.start = s1;
    req0.release_job = r0; req1.release_job = r1;
    fft_done = dn;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    req0.rd_en = 0; req1.rd_en = 0;
    rst_n = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s0, s1, r0, r1, dn;
    bit eg0, eg1, efs, ed0, ed1, eerr;
  } vec_t;

  vec_t tbl [0:20];

  initial begin
    //          s0 s1 r0 r1 dn  g0 g1 fs d0 d1 err
    tbl[0]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 1};
    tbl[10] = '{0, 1, 0, 1, 0,  0, 1, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 1};
    tbl[14] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tbl[17] = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 1};
    tbl[19] = '{0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1};
    tbl[20] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};

    req0.coeff = rand_coeff(); req1.coeff = rand_coeff();
    req0.rd_en = 0; req1.rd_en = 0; req0.rd_addr = '0; req1.rd_addr = '0;
    fft_dout = rand_dout();
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("rst_gnt0", req0.gnt, 0);
    check("rst_gnt1", req1.gnt, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_proto_err", proto_err, 0);
    do_reset();

    // vector table: ties, queueing, owner start in RUN, start with release
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].s0, tbl[i].s1, tbl[i].r0, tbl[i].r1, tbl[i].dn);
      #1;
      check($sformatf("tbl%0d_gnt0", i), req0.gnt, tbl[i].eg0);
      check($sformatf("tbl%0d_gnt1", i), req1.gnt, tbl[i].eg1);
      check($sformatf("tbl%0d_fs", i), fft_start, tbl[i].efs);
      check($sformatf("tbl%0d_done0", i), req0.done, tbl[i].ed0);
      check($sformatf("tbl%0d_done1", i), req1.done, tbl[i].ed1);
      check($sformatf("tbl%0d_err", i), proto_err, tbl[i].eerr);
      cyc();
    end

    // release while idle is a protocol error
    do_reset();
    drive(0, 0, 1, 0, 0); #1;
    check("rel_idle_before", proto_err, 0);
    cyc();
    drive(0, 0, 0, 0, 0); #1;
    check("rel_idle_after", proto_err, 1);
    cyc();
    cyc(); #1;
    check("rel_idle_sticky", proto_err, 1);

    // single port-1 job, read routing, then async reset in its first cycle
    do_reset();
    req0.coeff = rand_coeff(); req1.coeff = rand_coeff();
    drive(0, 1, 0, 0, 0); #1;
    check("b_gnt1_k", req1.gnt, 0);
    cyc();
    drive(0, 0, 0, 0, 0); #1;
    check("b_gnt1_k1", req1.gnt, 0);
    check("b_fs_k1", fft_start, 0);
    cyc(); #1;
    check("b_gnt1_k2", req1.gnt, 1);
    check("b_fs_k2", fft_start, 1);
    check("b_coeff_k2", fft_coeff_in === req1.coeff, 1);
    req1.rd_en = 1; req1.rd_addr = 7'd37; req0.rd_en = 1; req0.rd_addr = 7'd5; #1;
    check("b_rd_en", fft_rd_en, 1);
    check("b_rd_addr", fft_rd_addr, 37);
    rst_n = 1'b0; #1;
    check("b_arst_gnt1", req1.gnt, 0);
    check("b_arst_fs", fft_start, 0);
    check("b_arst_rd_en", fft_rd_en, 0);
    check("b_arst_rd_addr", fft_rd_addr, 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    req0.rd_en = 0;
    drive(0, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    cyc(); #1;
    check("b_restart_gnt1", req1.gnt, 1);
    check("b_restart_fs", fft_start, 1);
    check("b_restart_err", proto_err, 0);

    // port 0 queues behind port 1's job and launches two cycles after release
    drive(1, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1); #1;
    check("c_done1", req1.done, 1);
    check("c_done0", req0.done, 0);
    cyc();
    drive(0, 0, 0, 1, 0); #1;
    check("c_gnt1_r", req1.gnt, 1);
    cyc();
    drive(0, 0, 0, 0, 0); #1;
    check("c_gnt1_r1", req1.gnt, 0);
    check("c_gnt0_r1", req0.gnt, 0);
    cyc(); #1;
    check("c_gnt0_r2", req0.gnt, 1);
    check("c_fs_r2", fft_start, 1);
    check("c_coeff_r2", fft_coeff_in === req0.coeff, 1);
    drive(1, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0); #1;
    check("c_err_owner_start", proto_err, 1);
    check("c_no_extra_fs", fft_start, 0);
    cyc();
    cyc(); #1;
    check("c_no_extra_fs2", fft_start, 0);
    req1.rd_en = 0;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit s0, s1, r0, r1, dn;
      s0 = ($urandom_range(7) == 0);
      s1 = ($urandom_range(7) == 0);
      r0 = (m_owner == 0 && m_done_seen) ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
      r1 = (m_owner == 1 && m_done_seen) ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
      dn = (m_owner >= 0 && !m_done_seen) ? ($urandom_range(5) == 0) : ($urandom_range(99) == 0);
      drive(s0, s1, r0, r1, dn);
      req0.rd_en = $urandom_range(1); req1.rd_en = $urandom_range(1);
      req0.rd_addr = ADDR_W'($urandom); req1.rd_addr = ADDR_W'($urandom);
      if ($urandom_range(15) == 0) req0.coeff = rand_coeff();
      if ($urandom_range(15) == 0) req1.coeff = rand_coeff();
      fft_dout = rand_dout();
      rst_n = (i % 700 != 699);
      cyc();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
